// File: rtl/rv32_exec_pkg.sv
// Shared constants and types for the RV32 decode/execute stage.
package rv32_exec_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_PASS_B
    } alu_op_t;

endpackage

// File: rtl/rv32_exec_unit_key_mux.sv
// Keyed lookup mux: returns the data entry whose key matches key_in, zero on miss.
module key_mux
    import rv32_exec_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = XLEN_DEF
) (
    input  logic [KEY_LEN-1:0]                 key_in,
    input  logic [NR_KEY-1:0][KEY_LEN-1:0]     keys,
    input  logic [NR_KEY-1:0][DATA_LEN-1:0]    datas,
    output logic [DATA_LEN-1:0]                data_out
);

    always_comb begin
        data_out = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (keys[i] == key_in) data_out = datas[i];
        end
    end

endmodule

// File: rtl/rv32_exec_unit.sv
// Decode + execute stage of the single-cycle RV32 core with registered writeback/store/jump.
// Build option: EBREAK_HALT_EN makes EBREAK set a sticky halt that freezes all effects.
module rv32_exec_unit
    import rv32_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            jump,
    output logic [XLEN-1:0] jump_addr,
    output logic            halt,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic            alu_a_sel, alu_b_sel;
    alu_op_t         alu_op;
    logic [XLEN-1:0] imm;
    logic            legal, is_wb, is_store, is_jump, is_jalr, is_link, is_ebreak;

    always_comb begin
        alu_a_sel = 1'b1;
        alu_b_sel = 1'b0;
        alu_op    = ALU_ADD;
        imm       = '0;
        legal     = 1'b0;
        is_wb     = 1'b0;
        is_store  = 1'b0;
        is_jump   = 1'b0;
        is_jalr   = 1'b0;
        is_link   = 1'b0;
        is_ebreak = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal  = 1'b1;
                imm    = imm_u;
                alu_op = ALU_PASS_B;
                is_wb  = 1'b1;
            end
            OPC_AUIPC: begin
                legal     = 1'b1;
                imm       = imm_u;
                alu_a_sel = 1'b0;
                is_wb     = 1'b1;
            end
            OPC_JAL: begin
                legal     = 1'b1;
                imm       = imm_j;
                alu_a_sel = 1'b0;
                is_jump   = 1'b1;
                is_link   = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    legal   = 1'b1;
                    imm     = imm_i;
                    is_jump = 1'b1;
                    is_jalr = 1'b1;
                    is_link = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b000) begin
                    legal = 1'b1;
                    imm   = imm_i;
                    is_wb = 1'b1;
                end
            end
            OPC_OP: begin
                if (funct3 == 3'b000 && (funct7 == 7'h00 || funct7 == 7'h20)) begin
                    legal     = 1'b1;
                    alu_b_sel = 1'b1;
                    alu_op    = funct7[5] ? ALU_SUB : ALU_ADD;
                    is_wb     = 1'b1;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b010) begin
                    legal    = 1'b1;
                    imm      = imm_s;
                    is_store = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                is_ebreak = (instr == EBREAK_INSTR);
            end
            default: ;
        endcase
    end

    logic [XLEN-1:0] alu_a, alu_b, alu_res, pc_plus4;

    key_mux #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(XLEN)) u_mux_a (
        .key_in   (alu_a_sel),
        .keys     ({1'b1, 1'b0}),
        .datas    ({rs1_data, pc}),
        .data_out (alu_a)
    );

    key_mux #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(XLEN)) u_mux_b (
        .key_in   (alu_b_sel),
        .keys     ({1'b1, 1'b0}),
        .datas    ({rs2_data, imm}),
        .data_out (alu_b)
    );

    always_comb begin
        case (alu_op)
            ALU_ADD:    alu_res = alu_a + alu_b;
            ALU_SUB:    alu_res = alu_a - alu_b;
            ALU_PASS_B: alu_res = alu_b;
            default:    alu_res = '0;
        endcase
    end

    // Link value has its own adder so the ALU stays free for the jump target.
    assign pc_plus4 = pc + 32'd4;

    logic            wb_en_d, wb_en_q, mem_wen_d, mem_wen_q, jump_d, jump_q;
    logic            halt_d, halt_q, illegal_d, illegal_q;
    logic [4:0]      wb_addr_d, wb_addr_q;
    logic [XLEN-1:0] wb_data_d, wb_data_q, mem_addr_d, mem_addr_q;
    logic [XLEN-1:0] mem_wdata_d, mem_wdata_q, jump_addr_d, jump_addr_q;

    always_comb begin
        wb_en_d     = 1'b0;
        wb_addr_d   = '0;
        wb_data_d   = '0;
        mem_wen_d   = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        jump_d      = 1'b0;
        jump_addr_d = '0;
        illegal_d   = !(legal || is_ebreak);
        if (!halt_q) begin
            if ((is_wb || is_link) && rd != 5'd0) begin
                wb_en_d   = 1'b1;
                wb_addr_d = rd;
                wb_data_d = is_link ? pc_plus4 : alu_res;
            end
            if (is_store) begin
                mem_wen_d   = 1'b1;
                mem_addr_d  = alu_res;
                mem_wdata_d = rs2_data;
            end
            if (is_jump) begin
                jump_d      = 1'b1;
                jump_addr_d = {alu_res[XLEN-1:1], alu_res[0] & ~is_jalr};
            end
        end
`ifdef EBREAK_HALT_EN
        halt_d = halt_q | is_ebreak;
`else
        halt_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            jump_q      <= 1'b0;
            jump_addr_q <= '0;
            halt_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            jump_q      <= jump_d;
            jump_addr_q <= jump_addr_d;
            halt_q      <= halt_d;
            illegal_q   <= illegal_d;
        end
    end

    assign wb_en     = wb_en_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign jump      = jump_q;
    assign jump_addr = jump_addr_q;
    assign halt      = halt_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_rv32_exec_unit.sv
// Bench for rv32_exec_unit: instruction-level model checked every cycle plus literal vectors.
module tb_rv32_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'h0, pc = 32'h0, rs1_data = 32'h0, rs2_data = 32'h0;
    logic [4:0]  rs1_addr, rs2_addr, wb_addr;
    logic        wb_en, mem_wen, jump, halt, illegal;
    logic [31:0] wb_data, mem_addr, mem_wdata, jump_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv32_exec_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .jump(jump), .jump_addr(jump_addr), .halt(halt), .illegal(illegal)
    );

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        mem_wen;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        jump;
        logic [31:0] jump_addr;
        logic        halt;
        logic        illegal;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // What one instruction must do, straight from the ISA rules.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b, input bit halted);
        exp_t        e;
        logic [31:0] ii, is, iu, ij, res;
        bit          wr, ok;
        e  = '0;
        ii = {{20{i[31]}}, i[31:20]};
        is = {{20{i[31]}}, i[31:25], i[11:7]};
        iu = {i[31:12], 12'h000};
        ij = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        wr = 0; ok = 1; res = 0;
        case (i[6:0])
            7'h37: begin res = iu; wr = 1; end
            7'h17: begin res = p + iu; wr = 1; end
            7'h6F: begin res = p + 4; wr = 1; e.jump = 1; e.jump_addr = p + ij; end
            7'h67: if (i[14:12] == 0) begin
                       res = p + 4; wr = 1; e.jump = 1; e.jump_addr = (a + ii) & 32'hFFFF_FFFE;
                   end else ok = 0;
            7'h13: if (i[14:12] == 0) begin res = a + ii; wr = 1; end else ok = 0;
            7'h33: if (i[14:12] == 0 && i[31:25] == 7'h00) begin res = a + b; wr = 1; end
                   else if (i[14:12] == 0 && i[31:25] == 7'h20) begin res = a - b; wr = 1; end
                   else ok = 0;
            7'h23: if (i[14:12] == 3'd2) begin
                       e.mem_wen = 1; e.mem_addr = a + is; e.mem_wdata = b;
                   end else ok = 0;
            7'h73: ok = (i == 32'h0010_0073);
            default: ok = 0;
        endcase
        if (!ok) begin wr = 0; e.jump = 0; e.jump_addr = 0; e.mem_wen = 0; e.mem_addr = 0; e.mem_wdata = 0; end
        if (halted) begin wr = 0; e.jump = 0; e.jump_addr = 0; e.mem_wen = 0; e.mem_addr = 0; e.mem_wdata = 0; end
        if (wr && i[11:7] != 0) begin e.wb_en = 1; e.wb_addr = i[11:7]; e.wb_data = res; end
        e.illegal = !ok;
        return e;
    endfunction

    exp_t exp_q = '0;
    bit   exp_vld = 0;
    bit   m_halt = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_halt = 0;
            exp_q  = '0;
        end else begin
            exp_q = model(instr, pc, rs1_data, rs2_data, m_halt);
`ifdef EBREAK_HALT_EN
            if (instr == 32'h0010_0073) m_halt = 1;
`endif
            exp_q.halt = m_halt;
        end
        exp_vld = 1;
    end

    always @(negedge clk) begin
        if (exp_vld) begin
            chk("m.wb_en",     {31'b0, wb_en},   {31'b0, exp_q.wb_en});
            chk("m.wb_addr",   {27'b0, wb_addr}, {27'b0, exp_q.wb_addr});
            chk("m.wb_data",   wb_data,          exp_q.wb_data);
            chk("m.mem_wen",   {31'b0, mem_wen}, {31'b0, exp_q.mem_wen});
            chk("m.mem_addr",  mem_addr,         exp_q.mem_addr);
            chk("m.mem_wdata", mem_wdata,        exp_q.mem_wdata);
            chk("m.jump",      {31'b0, jump},    {31'b0, exp_q.jump});
            chk("m.jump_addr", jump_addr,        exp_q.jump_addr);
            chk("m.halt",      {31'b0, halt},    {31'b0, exp_q.halt});
            chk("m.illegal",   {31'b0, illegal}, {31'b0, exp_q.illegal});
        end
    end

    // Apply one instruction at a falling edge; return at the falling edge its results are visible.
    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        instr = i; pc = p; rs1_data = a; rs2_data = b;
        #1;
        t = i;
        chk("rs1_addr", {27'b0, rs1_addr}, {27'b0, t[19:15]});
        chk("rs2_addr", {27'b0, rs2_addr}, {27'b0, t[24:20]});
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst wb_en",   {31'b0, wb_en}, 32'h0);
        chk("rst wb_data", wb_data,        32'h0);
        chk("rst halt",    {31'b0, halt},  32'h0);
        rst = 1'b1;

        drive(32'h0050_0093, 32'h0, 32'h0, 32'h0);
        chk("addi wb_en", {31'b0, wb_en}, 32'h1);
        chk("addi wb_addr", {27'b0, wb_addr}, 32'h1);
        chk("addi wb_data", wb_data, 32'h5);

        drive(32'h0020_81B3, 32'h0, 32'h7, 32'h9);
        chk("add wb_data", wb_data, 32'd16);
        chk("add wb_addr", {27'b0, wb_addr}, 32'h3);
        drive(32'h4020_81B3, 32'h0, 32'h7, 32'h9);
        chk("sub wb_data", wb_data, 32'hFFFF_FFFE);

        drive(32'h1234_52B7, 32'h0, 32'h0, 32'h0);
        chk("lui wb_data", wb_data, 32'h1234_5000);
        drive(32'h0000_1297, 32'h8000_0000, 32'h0, 32'h0);
        chk("auipc wb_data", wb_data, 32'h8000_1000);

        drive(32'h0080_00EF, 32'h8000_0000, 32'h0, 32'h0);
        chk("jal jump", {31'b0, jump}, 32'h1);
        chk("jal jump_addr", jump_addr, 32'h8000_0008);
        chk("jal wb_data", wb_data, 32'h8000_0004);

        drive(32'h0020_A223, 32'h0, 32'h100, 32'hAB);
        chk("sw mem_wen", {31'b0, mem_wen}, 32'h1);
        chk("sw mem_addr", mem_addr, 32'h104);
        chk("sw mem_wdata", mem_wdata, 32'hAB);
        chk("sw wb_en", {31'b0, wb_en}, 32'h0);

        drive(32'hFE20_AE23, 32'h0, 32'h100, 32'h55);
        chk("sw neg mem_addr", mem_addr, 32'hFC);

        drive(32'h0051_0067, 32'h40, 32'h1000, 32'h0);
        chk("jalr x0 jump_addr", jump_addr, 32'h1004);
        chk("jalr x0 wb_en", {31'b0, wb_en}, 32'h0);

        drive(32'hFFF0_0113, 32'h0, 32'h0, 32'h0);
        chk("addi -1 wb_data", wb_data, 32'hFFFF_FFFF);
        drive(32'h0050_0013, 32'h0, 32'h0, 32'h0);
        chk("addi x0 wb_en", {31'b0, wb_en}, 32'h0);

        drive(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
        chk("bad illegal", {31'b0, illegal}, 32'h1);
        chk("bad wb_en", {31'b0, wb_en}, 32'h0);
        drive(32'h0000_40B3, 32'h0, 32'h3, 32'h4);
        chk("xor illegal", {31'b0, illegal}, 32'h1);

        drive(32'h0010_0073, 32'h0, 32'h0, 32'h0);
        chk("ebreak illegal", {31'b0, illegal}, 32'h0);
`ifdef EBREAK_HALT_EN
        chk("ebreak halt", {31'b0, halt}, 32'h1);
        drive(32'h0050_0093, 32'h0, 32'h0, 32'h0);
        chk("halted wb_en", {31'b0, wb_en}, 32'h0);
        chk("halt sticky", {31'b0, halt}, 32'h1);
`else
        chk("ebreak halt", {31'b0, halt}, 32'h0);
        drive(32'h0050_0093, 32'h0, 32'h0, 32'h0);
        chk("post-ebreak wb_en", {31'b0, wb_en}, 32'h1);
`endif

        #2 rst = 1'b0;
        #1;
        chk("async rst halt", {31'b0, halt}, 32'h0);
        chk("async rst wb_en", {31'b0, wb_en}, 32'h0);
        chk("async rst wb_data", wb_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(32'h0050_0093, 32'h0, 32'h0, 32'h0);
        chk("post-rst wb_data", wb_data, 32'h5);
        chk("post-rst wb_en", {31'b0, wb_en}, 32'h1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
